// File: rtl/cdc_tx_buffer_if.sv
// Local-side write port and downstream offer port of the crossing's source buffer.
// Latency: none; plain wires bundled for connection.
// Backpressure: full throttles the writer, aready (from the resynchronizer) throttles the offer.
interface cdc_tx_buffer_if #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
);
  // write side
  logic [WIDTH-1:0]    wr_data;
  logic                wr_en;
  logic                full;
  // offer side, facing the resynchronizer
  logic [WIDTH-1:0]    data_output;
  logic                asend;
  logic                aready;
  // status
  logic [DEPTH_LOG2:0] level;
  logic [7:0]          drop_cnt;

  // The environment around the buffer: local writer plus the resynchronizer's aready.
  modport master (
    output wr_data, wr_en, aready,
    input  full, data_output, asend, level, drop_cnt
  );

  // The buffer itself.
  modport slave (
    input  wr_data, wr_en, aready,
    output full, data_output, asend, level, drop_cnt
  );
endinterface

// File: rtl/cdc_tx_buffer.sv
// Source-side FIFO plus registered offer stage feeding the two-way-handshake resynchronizer.
// Latency: a word written into an idle buffer is offered (asend=1) one edge after it is stored.
// Backpressure: offer held stable until aready; full (pointer-derived only) rejects and counts writes.
module cdc_tx_buffer #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic            clka,
  input  logic            rst_n,
  cdc_tx_buffer_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0]   ptr_t;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  // Storage. Not reset: contents are only ever read behind a valid pointer.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  idx_t       wr_idx;
  idx_t       rd_idx;

  state_t     state;
  state_t     state_nxt;

  logic [WIDTH-1:0] dout_q;
  logic [7:0]       drop_q;

  logic       st_empty;
  logic       st_full;
  logic       wr_accept;
  logic       wr_reject;
  logic       pop;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  // Status comes only from the pointer registers, so full never depends on
  // this cycle's aready and the writer sees a clean registered-equivalent flag.
  assign st_empty  = (wr_ptr == rd_ptr);
  assign st_full   = (wr_idx == rd_idx) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign wr_accept = bus.wr_en && !st_full;
  assign wr_reject = bus.wr_en &&  st_full;

  // Offer-stage state register; dropping to EMPTY on reset kills asend at once.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and pop decision: refill the offer stage whenever it is idle or
  // being consumed this cycle and storage has a word (back-to-back offers).
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (!st_empty) begin
          pop       = 1'b1;
          state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (bus.aready) begin
          if (!st_empty) begin
            pop = 1'b1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Write into storage; a write is never forwarded straight to the offer stage.
  always_ff @(posedge clka) begin
    if (wr_accept) begin
      mem[wr_idx] <= bus.wr_data;
    end
  end

  // Pointer advance; write and pop on the same edge both happen.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // Offer data register: loads the head word on every pop, otherwise holds.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (pop) begin
      dout_q <= mem[rd_idx];
    end
  end

  // Saturating count of writes refused because storage was full.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (wr_reject && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.full        = st_full;
  assign bus.asend       = (state == ST_OFFER);
  assign bus.data_output = dout_q;
  assign bus.level       = wr_ptr - rd_ptr;
  assign bus.drop_cnt    = drop_q;

  // An unaccepted offer keeps asend high and its data unchanged.
  a_offer_hold: assert property (@(posedge clka) disable iff (!rst_n)
    (bus.asend && !bus.aready) |=> (bus.asend && $stable(bus.data_output)));

  // Occupancy can never exceed the storage depth.
  a_level_bound: assert property (@(posedge clka) disable iff (!rst_n)
    (bus.level <= (DEPTH_LOG2+1)'(DEPTH)));

  // Full flag and occupancy agree.
  a_full_level: assert property (@(posedge clka) disable iff (!rst_n)
    (bus.full == (bus.level == (DEPTH_LOG2+1)'(DEPTH))));

endmodule

// File: tb/tb_cdc_tx_buffer.sv
// Bench for cdc_tx_buffer: queue-level reference model, random and directed traffic.
// Checks every cycle at the falling edge; inputs are driven just after it.
// Reset is pulsed asynchronously mid-cycle to check the immediate drop of asend.
module tb_cdc_tx_buffer;

  localparam int WIDTH = 16;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;

  cdc_tx_buffer_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) bus ();

  cdc_tx_buffer #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;

  // Reference model: every accepted, undelivered word in arrival order. When
  // m_vld is set the head of the queue is the word being offered downstream.
  logic [WIDTH-1:0] m_acc[$];
  bit               m_vld = 1'b0;
  int               m_drop = 0;
  logic [WIDTH-1:0] rx[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int m_level();
    return m_acc.size() - (m_vld ? 1 : 0);
  endfunction

  task automatic check_outputs();
    int lvl;
    lvl = m_level();
    check_eq("asend", 32'(bus.asend), 32'(m_vld));
    if (m_vld) check_eq("data_output", 32'(bus.data_output), 32'(m_acc[0]));
    check_eq("level", 32'(bus.level), 32'(lvl));
    check_eq("full", 32'(bus.full), 32'(lvl == DEPTH));
    check_eq("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
  endtask

  // One clock: drive, record any transfer, advance model at the edge, check.
  task automatic cycle(input bit we, input logic [WIDTH-1:0] wd, input bit ar);
    int lvl;
    lvl = m_level();
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.aready  = ar;
    if (bus.asend && ar) begin
      if (m_acc.size() > 0)
        check_eq("deliver_order", 32'(bus.data_output), 32'(m_acc[0]));
      else
        check_eq("deliver_spurious", 32'(bus.asend), 32'd0);
      rx.push_back(bus.data_output);
    end
    @(posedge clka);
    if (m_vld && ar) begin
      void'(m_acc.pop_front());
    end
    if (!(m_vld && !ar)) m_vld = (lvl > 0);
    if (we) begin
      if (lvl < DEPTH) m_acc.push_back(wd);
      else if (m_drop < 255) m_drop++;
    end
    @(negedge clka);
    check_outputs();
  endtask

  // Called at a falling edge; asserts reset between edges and checks the async effect.
  task automatic pulse_reset();
    bus.wr_en  = 1'b0;
    bus.aready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_asend", 32'(bus.asend), 32'd0);
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_data", 32'(bus.data_output), 32'd0);
    check_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
    m_acc.delete();
    m_vld  = 1'b0;
    m_drop = 0;
    rx.delete();
    @(negedge clka);
    rst_n = 1'b1;
  endtask

  // mode 0: aready always 1, 1: alternating, 2: random.
  task automatic drain(input int mode, input string tag);
    int n;
    n = 0;
    while (m_acc.size() > 0 && n < 300) begin
      case (mode)
        0:       cycle(1'b0, '0, 1'b1);
        1:       cycle(1'b0, '0, n[0]);
        default: cycle(1'b0, '0, 1'($urandom_range(0, 1)));
      endcase
      n++;
    end
    check_eq(tag, 32'(m_acc.size()), 32'd0);
    check_eq({tag, "_asend"}, 32'(bus.asend), 32'd0);
  endtask

  initial begin
    int base;
    int sent;
    int guard;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.aready  = 1'b0;

    // Reset state
    #12;
    check_eq("reset_asend", 32'(bus.asend), 32'd0);
    check_eq("reset_data", 32'(bus.data_output), 32'd0);
    check_eq("reset_level", 32'(bus.level), 32'd0);
    check_eq("reset_full", 32'(bus.full), 32'd0);
    check_eq("reset_drop", 32'(bus.drop_cnt), 32'd0);
    @(negedge clka);
    rst_n = 1'b1;

    // Single word: stored at edge 0, offered after edge 1, taken at edge 2
    cycle(1'b1, 16'hA5A5, 1'b1);
    check_eq("single_e0_asend", 32'(bus.asend), 32'd0);
    cycle(1'b0, '0, 1'b1);
    check_eq("single_e1_asend", 32'(bus.asend), 32'd1);
    check_eq("single_e1_data", 32'(bus.data_output), 32'hA5A5);
    cycle(1'b0, '0, 1'b1);
    check_eq("single_e2_asend", 32'(bus.asend), 32'd0);
    check_eq("single_e2_level", 32'(bus.level), 32'd0);
    check_eq("single_rx_cnt", 32'(rx.size()), 32'd1);
    check_eq("single_rx_word", 32'(rx[0]), 32'hA5A5);

    // Stall hold
    base = rx.size();
    cycle(1'b1, 16'h1234, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b0);
      check_eq("stall_asend", 32'(bus.asend), 32'd1);
      check_eq("stall_data", 32'(bus.data_output), 32'h1234);
    end
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check_eq("stall_one_xfer", 32'(rx.size() - base), 32'd1);
    check_eq("stall_rx_word", 32'(rx[base]), 32'h1234);

    // Burst into a stalled consumer: 1 offered, 2..9 stored, 10 dropped
    base = rx.size();
    for (int i = 1; i <= 10; i++) cycle(1'b1, 16'(i), 1'b0);
    check_eq("burst_level", 32'(bus.level), 32'd8);
    check_eq("burst_full", 32'(bus.full), 32'd1);
    check_eq("burst_drop", 32'(bus.drop_cnt), 32'd1);
    check_eq("burst_head", 32'(bus.data_output), 32'd1);
    drain(1, "burst_drain");
    check_eq("burst_rx_cnt", 32'(rx.size() - base), 32'd9);
    for (int i = 0; i < 9 && base + i < rx.size(); i++)
      check_eq("burst_rx_seq", 32'(rx[base + i]), 32'(i + 1));

    // Back-to-back with aready tied high
    base = rx.size();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b1);
    drain(0, "b2b_drain");
    check_eq("b2b_rx_cnt", 32'(rx.size() - base), 32'd4);
    for (int i = 0; i < 4 && base + i < rx.size(); i++)
      check_eq("b2b_rx_seq", 32'(rx[base + i]), 32'(16'h0100 + i));

    // Wrap-around: 40 words, writer never overruns, random aready
    pulse_reset();
    sent  = 0;
    guard = 0;
    while (sent < 40 && guard < 2000) begin
      if ($urandom_range(0, 3) != 0 && m_level() < DEPTH) begin
        cycle(1'b1, 16'(16'h2000 + sent), 1'($urandom_range(0, 1)));
        sent++;
      end else begin
        cycle(1'b0, '0, 1'($urandom_range(0, 1)));
      end
      guard++;
    end
    check_eq("wrap_sent", 32'(sent), 32'd40);
    drain(2, "wrap_drain");
    check_eq("wrap_rx_cnt", 32'(rx.size()), 32'd40);
    for (int i = 0; i < 40 && i < rx.size(); i++)
      check_eq("wrap_rx_seq", 32'(rx[i]), 32'(16'h2000 + i));
    check_eq("wrap_drop", 32'(bus.drop_cnt), 32'd0);

    // Random traffic, overflow allowed
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 9) < 6), 16'($urandom), 1'($urandom_range(0, 2) != 0));
    drain(2, "rand_drain");

    // Drop counter saturation
    for (int i = 0; i < 275; i++) cycle(1'b1, 16'($urandom), 1'b0);
    check_eq("sat_drop", 32'(bus.drop_cnt), 32'd255);
    drain(0, "sat_drain");

    // Reset mid-burst
    pulse_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check_eq("midrst_pre_asend", 32'(bus.asend), 32'd1);
    check_eq("midrst_pre_level", 32'(bus.level), 32'd4);
    pulse_reset();
    cycle(1'b1, 16'hBEEF, 1'b1);
    drain(0, "midrst_drain");
    check_eq("midrst_rx_cnt", 32'(rx.size()), 32'd1);
    if (rx.size() > 0) check_eq("midrst_first", 32'(rx[0]), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
